// File: rtl/router_pkg.sv
// Shared types and widths for the noc_router stage and its companion traffic_gen.
package router_pkg;

    localparam int FLIT_SIZE   = 32;
    localparam int PORT_ADDR_W = 2;

    typedef struct packed {
        logic [FLIT_SIZE-1:0]   flit;
        logic                   valid;
        logic [PORT_ADDR_W-1:0] src_port;
    } router_pipeline_bus_t;

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO with occupancy count; a pop in the same cycle frees a slot for a push when full.
module router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/traffic_gen.sv
// Flit source emitting {8'hA5, sequence number}; the sequence advances once per emitted flit.
module traffic_gen
    import router_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic                 i_send,
    output logic [FLIT_SIZE-1:0] o_flit,
    output logic                 o_transmit
);

    logic [23:0] seq;

    assign o_transmit = i_start && i_send;
    assign o_flit     = {8'hA5, seq};

    always_ff @(posedge clk) begin
        if (reset_n)         seq <= '0;
        else if (o_transmit) seq <= seq + 24'd1;
    end

endmodule

// File: rtl/noc_router.sv
// Input-buffered router stage: FIFO between an on/off upstream link and a registered downstream output.
module noc_router
    import router_pkg::*;
#(
    parameter int BUF_DEPTH  = 8,
    parameter int OFF_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [FLIT_SIZE-1:0]   i_flit,
    input  logic [PORT_ADDR_W-1:0] i_port_addr,
    input  logic                   i_upstream_req,
    input  logic                   i_downstream_ack,
    output logic                   o_on_off,
    output logic                   o_downstream_req,
    output router_pipeline_bus_t   o_s2d
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic                 full;
    logic                 empty;
    logic                 push_ok;
    logic                 pop_ok;
    logic [FLIT_SIZE-1:0] head;

    assign pop_ok  = !empty && i_downstream_ack;
    assign push_ok = i_upstream_req && (!full || pop_ok);

    router_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_ok),
        .pop     (pop_ok),
        .wdata   (i_flit),
        .rdata   (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // o_on_off looks at next-cycle occupancy so the sender's one-cycle reaction is covered by OFF_THRESH.
    always_comb begin
        count_next = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            o_on_off         <= 1'b0;
            o_downstream_req <= 1'b0;
            o_s2d            <= '0;
        end else begin
            o_on_off <= (CW'(BUF_DEPTH) - count_next) > CW'(OFF_THRESH);
            if (pop_ok) begin
                o_downstream_req <= 1'b1;
                o_s2d.flit       <= head;
                o_s2d.valid      <= 1'b1;
                o_s2d.src_port   <= i_port_addr;
            end else begin
                o_downstream_req <= 1'b0;
                o_s2d.valid      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_router.sv
// Bench for noc_router: queue-based reference model for a single stage, then a traffic_gen -> router -> router chain.
module tb_noc_router;
    import router_pkg::*;

    localparam int BUF_DEPTH  = 8;
    localparam int OFF_THRESH = 2;
    localparam logic [PORT_ADDR_W-1:0] R1_PORT = 2'd1;
    localparam logic [PORT_ADDR_W-1:0] R2_PORT = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 chain_mode;
    logic                 drv_req;
    logic                 drv_ack;
    logic [FLIT_SIZE-1:0] drv_flit;
    logic                 r2_ack;
    logic                 tg_start;

    logic                 r1_req_in;
    logic                 r1_ack_in;
    logic [FLIT_SIZE-1:0] r1_flit_in;
    logic                 r1_on_off;
    logic                 r1_req;
    router_pipeline_bus_t r1_s2d;
    logic                 r2_on_off;
    logic                 r2_req;
    router_pipeline_bus_t r2_s2d;
    logic [FLIT_SIZE-1:0] tg_flit;
    logic                 tg_transmit;

    assign r1_req_in  = chain_mode ? tg_transmit : drv_req;
    assign r1_flit_in = chain_mode ? tg_flit     : drv_flit;
    assign r1_ack_in  = chain_mode ? r2_on_off   : drv_ack;

    traffic_gen u_tg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (tg_start),
        .i_send     (r1_on_off),
        .o_flit     (tg_flit),
        .o_transmit (tg_transmit)
    );

    noc_router #(.BUF_DEPTH(BUF_DEPTH), .OFF_THRESH(OFF_THRESH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_flit           (r1_flit_in),
        .i_port_addr      (R1_PORT),
        .i_upstream_req   (r1_req_in),
        .i_downstream_ack (r1_ack_in),
        .o_on_off         (r1_on_off),
        .o_downstream_req (r1_req),
        .o_s2d            (r1_s2d)
    );

    noc_router #(.BUF_DEPTH(BUF_DEPTH), .OFF_THRESH(OFF_THRESH)) u_r2 (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_flit           (r1_s2d.flit),
        .i_port_addr      (R2_PORT),
        .i_upstream_req   (r1_req),
        .i_downstream_ack (r2_ack),
        .o_on_off         (r2_on_off),
        .o_downstream_req (r2_req),
        .o_s2d            (r2_s2d)
    );

    int checks   = 0;
    int failures = 0;
    string phase = "init";

    logic [FLIT_SIZE-1:0] model_q[$];
    logic                 exp_req;
    logic                 exp_on_off;
    router_pipeline_bus_t exp_s2d;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s:%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // One clock of single-router stimulus; the model is a plain queue: pop to output first, then push if room.
    task automatic applyStimulus(input logic push, input logic [FLIT_SIZE-1:0] flit, input logic ack);
        drv_req  = push;
        drv_flit = flit;
        drv_ack  = ack;
        @(posedge clk);
        if (reset_n) begin
            model_q.delete();
            exp_req    = 1'b0;
            exp_on_off = 1'b0;
            exp_s2d    = '0;
        end else begin
            exp_req       = 1'b0;
            exp_s2d.valid = 1'b0;
            if (ack && model_q.size() > 0) begin
                exp_req        = 1'b1;
                exp_s2d.flit   = model_q.pop_front();
                exp_s2d.valid  = 1'b1;
                exp_s2d.src_port = R1_PORT;
            end
            if (push && model_q.size() < BUF_DEPTH) model_q.push_back(flit);
            exp_on_off = (BUF_DEPTH - model_q.size()) > OFF_THRESH;
        end
        #1;
        checkOutput("req",    64'(r1_req),    64'(exp_req));
        checkOutput("on_off", 64'(r1_on_off), 64'(exp_on_off));
        checkOutput("s2d",    64'(r1_s2d),    64'(exp_s2d));
    endtask

    initial begin
        int emerged;
        int emitted;
        int received;
        logic [23:0] exp_seq;

        chain_mode = 1'b0;
        drv_req    = 1'b0;
        drv_ack    = 1'b1;
        drv_flit   = '0;
        r2_ack     = 1'b1;
        tg_start   = 1'b0;
        reset_n    = 1'b1;
        exp_s2d    = '0;

        phase = "reset";
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b1, $urandom, 1'b1);
        reset_n = 1'b0;
        phase = "release";
        applyStimulus(1'b0, '0, 1'b1);

        phase = "single";
        applyStimulus(1'b1, 32'hA5000000, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("flit_out", 64'(r1_s2d.flit), 64'h00000000A5000000);
        applyStimulus(1'b0, '0, 1'b1);

        phase = "backpressure";
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0);
            checkOutput("on_off_vs_count", 64'(r1_on_off), ((i + 1) < 6) ? 64'd1 : 64'd0);
        end
        emerged = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (r1_req === 1'b1) emerged++;
        end
        checkOutput("emerged", 64'(emerged), 64'd8);

        phase = "full_push_pop";
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, $urandom, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1);

        phase = "mid_reset";
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, $urandom, 1'b0);
        reset_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, $urandom, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);

        phase = "random";
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)));

        phase = "chain";
        chain_mode = 1'b1;
        reset_n    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        emitted  = 0;
        received = 0;
        exp_seq  = '0;
        for (int i = 0; i < 70; i++) begin
            tg_start = (i < 30);
            r2_ack   = (i < 30) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tg_start && r1_on_off) emitted++;
            @(posedge clk);
            #1;
            if (r2_req === 1'b1) begin
                checkOutput("chain_flit", 64'(r2_s2d.flit), 64'({8'hA5, exp_seq}));
                checkOutput("chain_src",  64'(r2_s2d.src_port), 64'(R2_PORT));
                exp_seq = exp_seq + 24'd1;
                received++;
            end
        end
        checkOutput("chain_count", 64'(received), 64'(emitted));
        checkOutput("tg_seq", 64'(tg_flit[23:0]), 64'(emitted));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_router.md
Name: noc_router

Overview:
- Single-port input-buffered NoC router stage with on/off (credit-less) flow control on both sides.
- Accepts flits from an upstream source, which is either a traffic_gen or another noc_router.
- Buffers the flits in a FIFO and forwards them in order to a downstream noc_router over a request/on-off link.
- Routers chain: one router's o_downstream_req/o_s2d.flit feed the next router's i_upstream_req/i_flit, and the next router's o_on_off returns as i_downstream_ack.

Parameters:
- FLIT_SIZE, 32, flit width in bits (package constant).
- BUF_DEPTH, 8, input FIFO depth in flits, power of two.
- OFF_THRESH, 2, number of free slots at or below which o_on_off drops.
- PORT_ADDR_W, 2, width of the port address.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset; one clock, reset is synchronous and active-high.
- i_flit  in  FLIT_SIZE  upstream flit.
- i_port_addr  in  PORT_ADDR_W  static port id of this router input.
- i_upstream_req  in  1  i_flit valid this cycle.
- i_downstream_ack  in  1  downstream on/off: 1 = downstream may accept.
- o_on_off  out  1  1 = this router accepts flits.
- o_downstream_req  out  1  o_s2d.flit valid this cycle.
- o_s2d  out  router_pipeline_bus_t  {flit[FLIT_SIZE], valid, src_port[PORT_ADDR_W]}.

Behaviour:
- Reset (reset_n=1 at posedge):
  - FIFO emptied.
  - o_on_off=0 during reset, 1 from the first cycle after.
  - o_downstream_req=0; o_s2d all zero.
- Write side:
  - At a posedge with i_upstream_req=1 and FIFO not full, i_flit is pushed.
  - If the FIFO is full, the flit is dropped and the FIFO is unchanged.
- o_on_off:
  - Registered; o_on_off = (free slots > OFF_THRESH), computed from the next-state count.
  - Free slots = BUF_DEPTH − count.
  - OFF_THRESH covers the one-cycle reaction latency of the sender.
  - No flit is lost when the upstream stops in the cycle after it sees o_on_off=0.
- Read side:
  - At a posedge where the FIFO is non-empty and i_downstream_ack=1, the head is popped into the output register.
  - Output register contents: o_s2d.flit=head, o_s2d.valid=1, o_s2d.src_port=i_port_addr, o_downstream_req=1.
  - Otherwise o_downstream_req=0 and o_s2d.valid=0; o_s2d.flit holds its last value.
- Latency:
  - A flit sampled at edge k into an empty FIFO appears with o_downstream_req=1 after edge k+1 (2-cycle cut-through).
  - Sustained throughput is 1 flit/cycle.
- Simultaneous push and pop: allowed, including when full (pop frees the slot first) and when empty (no bypass; latency stays 2).
- Ordering: strict FIFO; no reordering; no flit duplication.
- Pointers: wrap modulo BUF_DEPTH; count is (log2 BUF_DEPTH)+1 bits.
- i_downstream_ack: must be tied to 1 by the integrator when no downstream router exists.
- Reset mid-stream: all buffered flits are discarded; outputs return to their reset values on the next edge.
- Companion block traffic_gen (separate module):
  - Ports: clk, reset_n, i_start, i_send, o_flit, o_transmit.
  - While i_start=1 and i_send=1, it drives o_transmit=1 and o_flit={8'hA5, 24-bit sequence counter}, which increments per emitted flit.
  - Otherwise o_transmit=0; the counter holds.
  - Reset clears the counter to 0.

Decomposition:
- router_pkg contains:
  - FLIT_SIZE and PORT_ADDR_W.
  - router_pipeline_bus_t, a packed struct {logic [FLIT_SIZE-1:0] flit; logic valid; logic [PORT_ADDR_W-1:0] src_port}.
- Natural sub-module: router_fifo, a synchronous FIFO with count output.
- traffic_gen is a separate top-level block, not instantiated inside noc_router.

Test Plan:
- Reset:
  - Hold reset_n=1 for 2 cycles with i_upstream_req=1 -> o_downstream_req=0, o_s2d=0, o_on_off=0 throughout.
  - First cycle after release -> o_on_off=1.
- Single flit: push 32'hA5000000 at edge k with i_downstream_ack=1 -> o_downstream_req=1 and o_s2d.flit=32'hA5000000 for exactly one cycle after edge k+1.
- Back-pressure: i_downstream_ack=0, push 8 flits ignoring o_on_off ->
  - o_on_off drops when count reaches 6.
  - 9th push is dropped.
  - After ack=1, exactly 8 flits emerge in order.
- Streaming: traffic_gen → router1 → router2 chain, i_start=1 for 30 cycles ->
  - router2 receives sequence 0,1,2,… with no gaps or duplicates.
  - Neither FIFO overflows.
- Simultaneous push/pop when full: count stays 8, no data loss, output order preserved.
- Mid-stream reset with 4 flits buffered -> FIFO empty next cycle; no further o_downstream_req until new pushes.
